// File: rtl/weight_update_engine.sv
// SGD weight update engine: queues {address, gradient} pairs and applies
// w <= sat(w - g * 2^-LR_SHIFT) through a read-modify-write of the weight SRAM.
module weight_update_engine #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned GRAD_WIDTH   = 16,
    parameter int unsigned WEIGHT_WIDTH = 16,
    parameter int unsigned SRAM_AW      = 10,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned LR_SHIFT     = 3
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          in_address,
    input  logic signed [GRAD_WIDTH-1:0]   in_value,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [SRAM_AW-1:0]             sram_addr,
    output logic                           sram_re,
    output logic                           sram_we,
    output logic [WEIGHT_WIDTH-1:0]        sram_wdata,
    input  logic [WEIGHT_WIDTH-1:0]        sram_rdata,
    output logic [15:0]                    update_count,
    output logic [15:0]                    drop_count,
    output logic                           busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRead, StWait, StWrite} state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]   fifo_addr_q [FIFO_DEPTH];
    logic [GRAD_WIDTH-1:0]   fifo_val_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]        wptr_q, rptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    in_ready_q;

    logic [SRAM_AW-1:0]      sram_addr_q;
    logic [GRAD_WIDTH-1:0]   g_q;
    logic [WEIGHT_WIDTH-1:0] w_q;
    logic [15:0]             update_count_q, drop_count_q;

    logic                    push, pop, drop;
    logic [ADDR_WIDTH-1:0]   head_addr;
    logic                    head_oor;

    logic signed [WEIGHT_WIDTH:0] g_ext, step, w_ext, diff;

    assign push      = in_valid & in_ready_q;
    assign head_addr = fifo_addr_q[rptr_q];
    assign head_oor  = (head_addr >> SRAM_AW) != '0;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head_oor) begin
                        drop = 1'b1;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead:  state_d = StWait;
            StWait:  state_d = StWrite;
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            in_ready_q     <= 1'b1;
            sram_addr_q    <= '0;
            g_q            <= '0;
            w_q            <= '0;
            update_count_q <= '0;
            drop_count_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            // Registered so in_ready never depends combinationally on in_valid.
            in_ready_q <= (count_d != FULL_CNT);
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (drop) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
            if (pop && !drop) begin
                sram_addr_q <= head_addr[SRAM_AW-1:0];
                g_q         <= fifo_val_q[rptr_q];
            end
            if (state_q == StWait) begin
                w_q <= sram_rdata;
            end
            if (state_q == StWrite) begin
                update_count_q <= update_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            fifo_addr_q[wptr_q] <= in_address;
            fifo_val_q[wptr_q]  <= in_value;
        end
    end

    // One extra bit of headroom lets the saturation test be a simple sign-bit compare.
    always_comb begin
        g_ext = {{(WEIGHT_WIDTH + 1 - GRAD_WIDTH){g_q[GRAD_WIDTH-1]}}, g_q};
        step  = g_ext >>> LR_SHIFT;
        w_ext = {w_q[WEIGHT_WIDTH-1], w_q};
        diff  = w_ext - step;
        if (diff[WEIGHT_WIDTH] != diff[WEIGHT_WIDTH-1]) begin
            sram_wdata = diff[WEIGHT_WIDTH] ? {1'b1, {(WEIGHT_WIDTH-1){1'b0}}}
                                            : {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
        end else begin
            sram_wdata = diff[WEIGHT_WIDTH-1:0];
        end
    end

    assign in_ready     = in_ready_q;
    assign sram_addr    = sram_addr_q;
    assign sram_re      = (state_q == StRead);
    assign sram_we      = (state_q == StWrite);
    assign update_count = update_count_q;
    assign drop_count   = drop_count_q;
    assign busy         = (count_q != '0) || (state_q != StIdle);

endmodule
